// File: rtl/xaxi_master_bridge_pkg.sv
// ============================================================================
// Module   : xaxi_master_bridge_pkg
// Brief    : Shared AXI encodings and burst-channel states for the master bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package xaxi_master_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Write path walks IDLE->ADDR->DATA->RESP; read path skips RESP.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } chan_state_t;

    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage : xaxi_master_bridge_pkg

`default_nettype wire

// File: rtl/xaxi_burst_channel.sv
// ============================================================================
// Module   : xaxi_burst_channel
// Brief    : Address phase, burst-parameter latch and beat counter for one path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xaxi_burst_channel
    import xaxi_master_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter bit HAS_RESP = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              aready_i,
    input  logic              beat_i,
    input  logic              done_i,
    input  logic              resp_i,
    output chan_state_t       state_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LEN_W-1:0]  len_o,
    output logic [LEN_W-1:0]  cnt_o,
    output logic              last_o
);

    localparam logic [LEN_W-1:0] c_cnt_one = LEN_W'(1);

    chan_state_t       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_addr  <= addr_i;
                        r_len   <= len_i;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (aready_i) begin
                        r_cnt   <= '0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Counter saturates at len so a full-range burst never wraps.
                    if (beat_i && (r_cnt != r_len)) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                    if (done_i) begin
                        r_state <= HAS_RESP ? ST_RESP : ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (resp_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state_o = r_state;
    assign addr_o  = r_addr;
    assign len_o   = r_len;
    assign cnt_o   = r_cnt;
    assign last_o  = (r_cnt == r_len);

endmodule : xaxi_burst_channel

`default_nettype wire

// File: rtl/xaxi_master_bridge.sv
// ============================================================================
// Module   : xaxi_master_bridge
// Brief    : Simple write/read burst interface to AXI4 master, one burst per path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xaxi_master_bridge
    import xaxi_master_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LEN_W    = 8,
    parameter int AXI_ID_W = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // upstream write
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    input  logic [ADDR_W-1:0]     s_waddr_i,
    input  logic [DATA_W-1:0]     s_wdata_i,
    input  logic [DATA_W/8-1:0]   s_wstrb_i,
    input  logic [LEN_W-1:0]      s_wlen_i,
    output logic                  s_wlast_o,
    // upstream read
    input  logic                  s_rvalid_i,
    output logic                  s_rready_o,
    input  logic [ADDR_W-1:0]     s_raddr_i,
    output logic [DATA_W-1:0]     s_rdata_o,
    input  logic [LEN_W-1:0]      s_rlen_i,
    output logic                  s_rlast_o,
    output logic                  error_o,
    // AXI AW
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [ADDR_W-1:0]     axi_awaddr_o,
    output logic [7:0]            axi_awlen_o,
    output logic [2:0]            axi_awsize_o,
    output logic [1:0]            axi_awburst_o,
    output logic [AXI_ID_W-1:0]   axi_awid_o,
    // AXI W
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    output logic [DATA_W-1:0]     axi_wdata_o,
    output logic [DATA_W/8-1:0]   axi_wstrb_o,
    output logic                  axi_wlast_o,
    // AXI B
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    input  logic [1:0]            axi_bresp_i,
    input  logic [AXI_ID_W-1:0]   axi_bid_i,
    // AXI AR
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDR_W-1:0]     axi_araddr_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    // AXI R
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic [DATA_W-1:0]     axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i
);

    localparam logic [2:0] c_axi_size = axi_size(DATA_W);

    chan_state_t       w_wr_state;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [LEN_W-1:0]  w_wr_len;
    logic [LEN_W-1:0]  w_wr_cnt;
    logic              w_wr_last;
    logic              w_wr_in_data;
    logic              w_wr_beat;
    logic              w_wr_done;

    chan_state_t       w_rd_state;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [LEN_W-1:0]  w_rd_len;
    logic [LEN_W-1:0]  w_rd_cnt;
    logic              w_rd_last;
    logic              w_rd_in_data;
    logic              w_rd_beat;
    logic              w_rd_done;

    logic              r_error;

    // ---------------- write path ----------------
    assign w_wr_in_data = (w_wr_state == ST_DATA);
    assign w_wr_beat    = w_wr_in_data & s_wvalid_i & axi_wready_i;
    assign w_wr_done    = w_wr_beat & w_wr_last;

    xaxi_burst_channel #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .HAS_RESP (1'b1)
    ) u_wr_chan (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (s_wvalid_i),
        .addr_i   (s_waddr_i),
        .len_i    (s_wlen_i),
        .aready_i (axi_awready_i),
        .beat_i   (w_wr_beat),
        .done_i   (w_wr_done),
        .resp_i   (axi_bvalid_i),
        .state_o  (w_wr_state),
        .addr_o   (w_wr_addr),
        .len_o    (w_wr_len),
        .cnt_o    (w_wr_cnt),
        .last_o   (w_wr_last)
    );

    assign axi_awvalid_o = (w_wr_state == ST_ADDR);
    assign axi_awaddr_o  = w_wr_addr;
    assign axi_awsize_o  = c_axi_size;
    assign axi_awburst_o = AXI_BURST_INCR;
    assign axi_awid_o    = '0;

    assign axi_wvalid_o  = w_wr_in_data & s_wvalid_i;
    assign axi_wdata_o   = s_wdata_i;
    assign axi_wstrb_o   = s_wstrb_i;
    assign axi_wlast_o   = w_wr_in_data & w_wr_last;
    assign s_wready_o    = w_wr_in_data & axi_wready_i;
    assign s_wlast_o     = w_wr_in_data & w_wr_last;
    assign axi_bready_o  = (w_wr_state == ST_RESP);

    // ---------------- read path ----------------
    assign w_rd_in_data = (w_rd_state == ST_DATA);
    assign w_rd_beat    = w_rd_in_data & axi_rvalid_i & s_rvalid_i;
    assign w_rd_done    = w_rd_beat & axi_rlast_i;

    xaxi_burst_channel #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .HAS_RESP (1'b0)
    ) u_rd_chan (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (s_rvalid_i),
        .addr_i   (s_raddr_i),
        .len_i    (s_rlen_i),
        .aready_i (axi_arready_i),
        .beat_i   (w_rd_beat),
        .done_i   (w_rd_done),
        .resp_i   (1'b0),
        .state_o  (w_rd_state),
        .addr_o   (w_rd_addr),
        .len_o    (w_rd_len),
        .cnt_o    (w_rd_cnt),
        .last_o   (w_rd_last)
    );

    assign axi_arvalid_o = (w_rd_state == ST_ADDR);
    assign axi_araddr_o  = w_rd_addr;
    assign axi_arsize_o  = c_axi_size;
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_arid_o    = '0;

    assign axi_rready_o  = w_rd_in_data & s_rvalid_i;
    assign s_rready_o    = w_rd_in_data & axi_rvalid_i;
    assign s_rlast_o     = w_rd_in_data & axi_rvalid_i & axi_rlast_i;
    assign s_rdata_o     = axi_rdata_i;

    // ---------------- AXI length fields ----------------
    generate
        if (LEN_W < 8) begin : g_len_pad
            assign axi_awlen_o = {{(8-LEN_W){1'b0}}, w_wr_len};
            assign axi_arlen_o = {{(8-LEN_W){1'b0}}, w_rd_len};
        end else begin : g_len_full
            assign axi_awlen_o = w_wr_len[7:0];
            assign axi_arlen_o = w_rd_len[7:0];
        end
    endgenerate

    // Sticky until reset: any non-OKAY write response or read beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_error <= 1'b0;
        end else if ((axi_bvalid_i && axi_bready_o && (axi_bresp_i != AXI_RESP_OKAY)) ||
                     (axi_rvalid_i && axi_rready_o && (axi_rresp_i != AXI_RESP_OKAY))) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, axi_bid_i, axi_rid_i, w_wr_cnt, w_rd_cnt, w_rd_last};

endmodule : xaxi_master_bridge

`default_nettype wire

// File: tb/tb_xaxi_master_bridge.sv
// ============================================================================
// Module   : tb_xaxi_master_bridge
// Brief    : Directed bench with transaction scoreboard for xaxi_master_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xaxi_master_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int ID_W   = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_wvalid = 0, s_rvalid = 0;
    logic [ADDR_W-1:0] s_waddr = '0, s_raddr = '0;
    logic [DATA_W-1:0] s_wdata = '0;
    logic [3:0]        s_wstrb = '0;
    logic [LEN_W-1:0]  s_wlen = '0, s_rlen = '0;
    logic              awready = 0, wready = 0, bvalid = 0, arready = 0;
    logic              rvalid = 0, rlast = 0;
    logic [1:0]        bresp = '0, rresp = '0;
    logic [DATA_W-1:0] rdata = '0;
    logic [ID_W-1:0]   bid = '0, rid = '0;

    logic              s_wready_o, s_wlast_o, s_rready_o, s_rlast_o, error_o;
    logic [DATA_W-1:0] s_rdata_o;
    logic              awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize;
    logic [1:0]        awburst, arburst;
    logic [ID_W-1:0]   awid, arid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;

    xaxi_master_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .AXI_ID_W(ID_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_wvalid_i(s_wvalid), .s_wready_o(s_wready_o), .s_waddr_i(s_waddr),
        .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wlen_i(s_wlen), .s_wlast_o(s_wlast_o),
        .s_rvalid_i(s_rvalid), .s_rready_o(s_rready_o), .s_raddr_i(s_raddr),
        .s_rdata_o(s_rdata_o), .s_rlen_i(s_rlen), .s_rlast_o(s_rlast_o), .error_o(error_o),
        .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awaddr_o(awaddr),
        .axi_awlen_o(awlen), .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awid_o(awid),
        .axi_wvalid_o(wvalid), .axi_wready_i(wready), .axi_wdata_o(wdata),
        .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
        .axi_bvalid_i(bvalid), .axi_bready_o(bready), .axi_bresp_i(bresp), .axi_bid_i(bid),
        .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
        .axi_arlen_o(arlen), .axi_arsize_o(arsize), .axi_arburst_o(arburst), .axi_arid_o(arid),
        .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata),
        .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rid_i(rid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected-transaction queues, filled by the stimulus tasks.
    logic [ADDR_W-1:0] q_aw_addr[$], q_ar_addr[$];
    logic [7:0]        q_aw_len[$],  q_ar_len[$];
    logic [DATA_W-1:0] q_w_data[$],  q_r_data[$];
    logic [3:0]        q_w_strb[$];
    logic              q_w_last[$],  q_r_last[$];
    logic              model_err = 1'b0;
    int                n_wbeats = 0, n_wlast = 0, n_rdeliv = 0, n_rlast = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=handshake required=none at %0t", name, $time);
    endtask

    function automatic logic [3:0] strb_of(input int i);
        return 4'hF ^ i[3:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compares every handshake and the sticky error flag on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            model_err = 1'b0;
        end else begin
            chk("error_o", error_o, model_err);
            if (awvalid) begin
                chk("awburst", awburst, 2'b01);
                chk("awsize", awsize, 3'd2);
                chk("awid", awid, 1'b0);
            end
            if (arvalid) begin
                chk("arburst", arburst, 2'b01);
                chk("arsize", arsize, 3'd2);
                chk("arid", arid, 1'b0);
            end
            if (awvalid && awready) begin
                if (q_aw_addr.size() == 0) unexpected("aw_extra");
                else begin
                    chk("awaddr", awaddr, q_aw_addr.pop_front());
                    chk("awlen", awlen, q_aw_len.pop_front());
                end
            end
            if (wvalid && wready) begin
                n_wbeats++;
                if (wlast) n_wlast++;
                if (q_w_data.size() == 0) unexpected("w_extra");
                else begin
                    chk("wdata", wdata, q_w_data.pop_front());
                    chk("wstrb", wstrb, q_w_strb.pop_front());
                    chk("wlast", wlast, q_w_last[0]);
                    chk("s_wlast_o", s_wlast_o, q_w_last.pop_front());
                    chk("s_wready_o_beat", s_wready_o, 1'b1);
                end
            end
            if (arvalid && arready) begin
                if (q_ar_addr.size() == 0) unexpected("ar_extra");
                else begin
                    chk("araddr", araddr, q_ar_addr.pop_front());
                    chk("arlen", arlen, q_ar_len.pop_front());
                end
            end
            if (rvalid && rready) begin
                chk("s_rready_o", s_rready_o, 1'b1);
                n_rdeliv++;
                if (s_rlast_o) n_rlast++;
                if (q_r_data.size() == 0) unexpected("r_extra");
                else begin
                    chk("s_rdata_o", s_rdata_o, q_r_data.pop_front());
                    chk("s_rlast_o", s_rlast_o, q_r_last.pop_front());
                end
            end
            if (bvalid && bready && bresp != 2'b00) model_err = 1'b1;
            if (rvalid && rready && rresp != 2'b00) model_err = 1'b1;
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dbase, input logic [15:0] pat,
                            input logic [1:0] resp);
        int beat, k, n;
        bit xfer;
        q_aw_addr.push_back(addr);
        q_aw_len.push_back(len);
        for (int i = 0; i <= int'(len); i++) begin
            q_w_data.push_back(dbase + 32'(i));
            q_w_strb.push_back(strb_of(i));
            q_w_last.push_back(i == int'(len));
        end
        s_waddr = addr; s_wlen = len; s_wvalid = 1'b1;
        s_wdata = dbase; s_wstrb = strb_of(0);
        wready = 1'b1;
        tick;
        chk("aw_latency", awvalid, 1'b1);
        chk("wvalid_in_addr", wvalid, 1'b0);
        chk("s_wready_in_addr", s_wready_o, 1'b0);
        n = 0;
        while (!awvalid && n < 10) begin tick; n++; end
        if (!awvalid) chk("aw_timeout", 1'b0, 1'b1);
        awready = 1'b1;
        tick;
        awready = 1'b0;
        beat = 0; k = 0;
        while (beat <= int'(len) && k < 64) begin
            s_wdata = dbase + 32'(beat);
            s_wstrb = strb_of(beat);
            wready = (k < 16) ? pat[k] : 1'b1;
            #1;
            xfer = wvalid && wready;
            tick;
            if (xfer) beat++;
            k++;
        end
        if (beat <= int'(len)) chk("w_timeout", 32'(beat), 32'(len) + 1);
        wready = 1'b0; s_wvalid = 1'b0;
        repeat (2) begin
            chk("s_wready_in_resp", s_wready_o, 1'b0);
            chk("bready_in_resp", bready, 1'b1);
            tick;
        end
        bvalid = 1'b1; bresp = resp;
        tick;
        bvalid = 1'b0; bresp = 2'b00;
        chk("bready_after_resp", bready, 1'b0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] dbase, input logic [15:0] pat,
                           input logic [1:0] resp);
        int beat, k, n;
        bit xfer;
        q_ar_addr.push_back(addr);
        q_ar_len.push_back(len);
        for (int i = 0; i <= int'(len); i++) begin
            q_r_data.push_back(dbase + 32'(i));
            q_r_last.push_back(i == int'(len));
        end
        s_raddr = addr; s_rlen = len; s_rvalid = 1'b1;
        tick;
        chk("ar_latency", arvalid, 1'b1);
        n = 0;
        while (!arvalid && n < 10) begin tick; n++; end
        if (!arvalid) chk("ar_timeout", 1'b0, 1'b1);
        arready = 1'b1;
        tick;
        arready = 1'b0;
        beat = 0; k = 0;
        while (beat <= int'(len) && k < 64) begin
            rvalid = (k < 16) ? pat[k] : 1'b1;
            rdata  = dbase + 32'(beat);
            rlast  = (beat == int'(len));
            rresp  = resp;
            #1;
            xfer = rvalid && rready;
            tick;
            if (xfer) beat++;
            k++;
        end
        if (beat <= int'(len)) chk("r_timeout", 32'(beat), 32'(len) + 1);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; s_rvalid = 1'b0;
        chk("arvalid_after_read", arvalid, 1'b0);
    endtask

    initial begin
        int wb0, wl0, rd0, rl0;
        // Reset state (asynchronous: visible before any clock edge)
        #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_s_wready", s_wready_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_awlen", awlen, 8'h0);
        tick; tick;
        rst = 1'b0;
        tick;

        // Write 0x100 len 3, wready 1,0,1,1,1
        wb0 = n_wbeats; wl0 = n_wlast;
        do_write(32'h100, 8'd3, 32'hA0, 16'hFFFD, 2'b00);
        chk("wr1_beats", 32'(n_wbeats - wb0), 32'd4);
        chk("wr1_wlast_count", 32'(n_wlast - wl0), 32'd1);

        // Read 0x40 len 0, data 0xDEAD
        rd0 = n_rdeliv; rl0 = n_rlast;
        do_read(32'h40, 8'd0, 32'hDEAD, 16'hFFFF, 2'b00);
        chk("rd1_pulses", 32'(n_rdeliv - rd0), 32'd1);
        chk("rd1_rlast_count", 32'(n_rlast - rl0), 32'd1);
        tick;

        // Concurrent write len 1 and read len 2 with a read stall
        wb0 = n_wbeats; rd0 = n_rdeliv;
        fork
            do_write(32'h200, 8'd1, 32'hB0, 16'hFFFF, 2'b00);
            do_read(32'h300, 8'd2, 32'hC0, 16'hFFFD, 2'b00);
        join
        chk("cc_wbeats", 32'(n_wbeats - wb0), 32'd2);
        chk("cc_rbeats", 32'(n_rdeliv - rd0), 32'd3);
        chk("cc_error", error_o, 1'b0);
        tick;

        // SLVERR on write, then OKAY read: error stays set
        do_write(32'h500, 8'd0, 32'hE0, 16'hFFFF, 2'b10);
        chk("err_after_slverr", error_o, 1'b1);
        do_read(32'h600, 8'd1, 32'hF0, 16'hFFFF, 2'b00);
        chk("err_sticky", error_o, 1'b1);
        tick;

        // Reset during W_DATA after two beats
        q_aw_addr.push_back(32'h700); q_aw_len.push_back(8'd3);
        for (int i = 0; i < 2; i++) begin
            q_w_data.push_back(32'h70 + 32'(i));
            q_w_strb.push_back(strb_of(i));
            q_w_last.push_back(1'b0);
        end
        s_waddr = 32'h700; s_wlen = 8'd3; s_wvalid = 1'b1;
        s_wdata = 32'h70; s_wstrb = strb_of(0);
        tick;
        awready = 1'b1;
        tick;
        awready = 1'b0; wready = 1'b1;
        tick;
        s_wdata = 32'h71; s_wstrb = strb_of(1);
        tick;
        rst = 1'b1;
        #1;
        chk("mid_rst_wvalid", wvalid, 1'b0);
        chk("mid_rst_s_wready", s_wready_o, 1'b0);
        chk("mid_rst_s_wlast", s_wlast_o, 1'b0);
        chk("mid_rst_awvalid", awvalid, 1'b0);
        chk("mid_rst_bready", bready, 1'b0);
        chk("mid_rst_error", error_o, 1'b0);
        s_wvalid = 1'b0; wready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        wb0 = n_wbeats;
        do_write(32'h800, 8'd0, 32'h80, 16'hFFFF, 2'b00);
        chk("post_rst_wbeats", 32'(n_wbeats - wb0), 32'd1);
        tick; tick;

        chk("aw_queue_drained", 32'(q_aw_addr.size()), 32'd0);
        chk("w_queue_drained", 32'(q_w_data.size()), 32'd0);
        chk("ar_queue_drained", 32'(q_ar_addr.size()), 32'd0);
        chk("r_queue_drained", 32'(q_r_data.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_xaxi_master_bridge

`default_nettype wire
